// File: rtl/uart_rx_pkg.sv
// Shared definitions for the bit-strobed UART frame receiver: FSM state
// encoding and the legal ranges for the frame-shape parameters.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_e;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  // True when the data width and stop-bit count describe a frame we can build.
  function automatic bit cfg_legal(input int data_bits, input int stop_bits);
    return (data_bits >= DATA_BITS_MIN) && (data_bits <= DATA_BITS_MAX) &&
           (stop_bits >= STOP_BITS_MIN) && (stop_bits <= STOP_BITS_MAX);
  endfunction

endpackage

// File: rtl/uart_rx_shifter.sv
// Data-bit datapath of the frame receiver: shift register, bit counter and
// running XOR of the bits shifted in. clr has priority over shift_en.
module uart_rx_shifter
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 shift_en,
  input  logic                 clr,
  input  logic                 in_bit,
  output logic [DATA_BITS-1:0] data,
  output logic                 cnt_last,
  output logic                 parity
);

  localparam int CNT_W = $clog2(DATA_BITS);

  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 par_q, par_d;

  assign cnt_last = (cnt_q == CNT_W'(DATA_BITS - 1));
  assign data     = sh_q;
  assign parity   = par_q;

  // Next-state for shifter, counter and running parity.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    sh_d  = sh_q;
    cnt_d = cnt_q;
    par_d = par_q;
    if (clr) begin
      sh_d  = '0;
      cnt_d = '0;
      par_d = 1'b0;
    end else if (shift_en) begin
      if (MSB_FIRST) sh_d = {sh_q[DATA_BITS-2:0], in_bit};
      else           sh_d = {in_bit, sh_q[DATA_BITS-1:1]};
      cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
      par_d = par_q ^ in_bit;
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sh_q  <= '0;
      cnt_q <= '0;
      par_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of its neighbours.
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      par_q <= par_d;
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// Bit-strobed UART frame receiver. Consumes one en strobe per bit centre,
// checks start/stop framing and delivers data words to the message layer.
// Optional parity check is built when the macro UART_RX_PARITY_EN is defined.
module uart_frame_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 en,
  input  logic                 in_bit,
  input  logic                 init_frame,
  output logic                 useful_in_bit,
  output logic                 last_bit,
  output logic                 busy,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 msg_err
);

  if (!cfg_legal(DATA_BITS, STOP_BITS)) begin : g_bad_cfg
    $error("uart_frame_rx: DATA_BITS must be 5..9 and STOP_BITS 1..2");
  end

  state_e               state_q, state_d;
  logic                 scnt_q, scnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 msg_err_q, msg_err_d;

  logic                 shift_en, clr;
  logic [DATA_BITS-1:0] sh_data;
  logic                 cnt_last;
  logic                 sh_parity;

`ifdef UART_RX_PARITY_EN
  logic par_mis_q, par_mis_d;
`else
  logic unused_parity;
  assign unused_parity = sh_parity ^ PARITY_ODD;
`endif

  uart_rx_shifter #(
    .DATA_BITS (DATA_BITS),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .shift_en (shift_en),
    .clr      (clr),
    .in_bit   (in_bit),
    .data     (sh_data),
    .cnt_last (cnt_last),
    .parity   (sh_parity)
  );

  // Frame FSM: next state, datapath controls and result pulses.
  always_comb begin
    state_d      = state_q;
    scnt_d       = scnt_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    shift_en     = 1'b0;
    clr          = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_mis_d    = par_mis_q;
`endif
    if (en) begin
      if (init_frame) begin
        // Message start (from IDLE) or restart: any partial frame is dropped.
        state_d = ST_START;
        clr     = 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_START: begin
            if (!in_bit) begin
              state_d = ST_DATA;
              clr     = 1'b1;
            end else begin
              state_d = ST_IDLE;   // line idle in start slot: end of message
            end
          end
          ST_DATA: begin
            shift_en = 1'b1;
            if (cnt_last) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PAR;
`else
              state_d = ST_STOP;
`endif
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PAR: begin
            par_mis_d = in_bit ^ sh_parity ^ PARITY_ODD;
            state_d   = ST_STOP;
          end
`endif
          ST_STOP: begin
            if (in_bit) begin
              if ((STOP_BITS == 2) && !scnt_q) begin
                scnt_d = 1'b1;
              end else begin
                out_valid_d = 1'b1;
                out_data_d  = sh_data;
`ifdef UART_RX_PARITY_EN
                parity_err_d = par_mis_q;
`endif
                state_d     = ST_START;
              end
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
    // Stop-bit counter only lives while the FSM stays in STOP.
    if (state_d != ST_STOP) scnt_d = 1'b0;
    // Error pulses set the sticky flag; a new message clears it, set wins.
    msg_err_d = frame_err_q | parity_err_q | (msg_err_q & ~init_frame);
  end

  // FSM state and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      scnt_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      msg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      scnt_q       <= scnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      msg_err_q    <= msg_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity mismatch captured in PAR, reported with the frame in STOP.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) par_mis_q <= 1'b0;
    else        par_mis_q <= par_mis_d;
  end
`endif

  assign useful_in_bit = (state_q == ST_DATA);
  assign last_bit      = (state_q == ST_DATA) && cnt_last;
  assign busy          = (state_q != ST_IDLE);
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign frame_err     = frame_err_q;
  assign parity_err    = parity_err_q;
  assign msg_err       = msg_err_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx. Two instances: A with defaults
// (8 data bits, MSB first, 1 stop), B with 5 data bits, LSB first, 2 stops.
// Expected frames come from a per-frame model (value in, value out) kept in queues.
module tb_uart_frame_rx;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam bit PODD = 1'b0;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic en_a, bit_a, init_a, en_b, bit_b, init_b;
  logic a_useful, a_last, a_busy, a_valid, a_ferr, a_perr, a_merr;
  logic b_useful, b_last, b_busy, b_valid, b_ferr, b_perr, b_merr;
  logic [7:0] a_data;
  logic [4:0] b_data;

  uart_frame_rx #(.DATA_BITS(8), .STOP_BITS(1), .MSB_FIRST(1'b1), .PARITY_ODD(PODD)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .en(en_a), .in_bit(bit_a), .init_frame(init_a),
    .useful_in_bit(a_useful), .last_bit(a_last), .busy(a_busy), .out_valid(a_valid),
    .out_data(a_data), .frame_err(a_ferr), .parity_err(a_perr), .msg_err(a_merr));

  uart_frame_rx #(.DATA_BITS(5), .STOP_BITS(2), .MSB_FIRST(1'b0), .PARITY_ODD(PODD)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .en(en_b), .in_bit(bit_b), .init_frame(init_b),
    .useful_in_bit(b_useful), .last_bit(b_last), .busy(b_busy), .out_valid(b_valid),
    .out_data(b_data), .frame_err(b_ferr), .parity_err(b_perr), .msg_err(b_merr));

  typedef struct { bit ferr; int data; bit perr; } ev_t;
  typedef struct { bit init; bit in_bit; logic [2:0] exp; } vec_t;

  ev_t exp_a[$], obs_a[$], exp_b[$], obs_b[$];
  int  checks = 0;
  int  errors = 0;
  int  gap_max = 0;
  bit  merr_exp;

  // Collect result pulses; a stray parity pulse or a moving out_data is logged as a bogus event.
  logic [7:0] hold_a;
  logic [4:0] hold_b;
  always @(negedge CLK) begin
    if (!RST_N) begin
      hold_a <= '0;
      hold_b <= '0;
    end else begin
      if (a_valid) obs_a.push_back('{ferr:1'b0, data:int'(a_data), perr:a_perr});
      else if (a_data != hold_a) obs_a.push_back('{ferr:1'b1, data:-2, perr:1'b0});
      if (a_ferr) obs_a.push_back('{ferr:1'b1, data:0, perr:1'b0});
      if (a_perr && !a_valid) obs_a.push_back('{ferr:1'b1, data:-1, perr:1'b1});
      if (b_valid) obs_b.push_back('{ferr:1'b0, data:int'(b_data), perr:b_perr});
      else if (b_data != hold_b) obs_b.push_back('{ferr:1'b1, data:-2, perr:1'b0});
      if (b_ferr) obs_b.push_back('{ferr:1'b1, data:0, perr:1'b0});
      if (b_perr && !b_valid) obs_b.push_back('{ferr:1'b1, data:-1, perr:1'b1});
      hold_a <= a_data;
      hold_b <= b_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_ev(input ev_t e);
    return {14'd0, e.ferr, e.perr, e.data[15:0]};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // One strobed bit on unit u after 0..gap_max unstrobed cycles; comb = {busy,useful,last} before the edge.
  task automatic en_cycle(input bit u, input bit b, input bit init, output logic [2:0] comb);
    int g = int'($urandom_range(gap_max, 0));
    repeat (g) begin
      if (u) bit_b = 1'($urandom); else bit_a = 1'($urandom);
      @(posedge CLK); #1;
    end
    if (u) begin en_b = 1'b1; bit_b = b; init_b = init; end
    else   begin en_a = 1'b1; bit_a = b; init_a = init; end
    @(negedge CLK);
    comb = u ? {b_busy, b_useful, b_last} : {a_busy, a_useful, a_last};
    @(posedge CLK); #1;
    en_a = 1'b0; en_b = 1'b0; init_a = 1'b0; init_b = 1'b0;
  endtask

  task automatic start_msg(input bit u);
    logic [2:0] c;
    merr_exp = 1'b0;
    en_cycle(u, 1'($urandom), 1'b1, c);
  endtask

  task automatic end_msg(input bit u);
    logic [2:0] c;
    en_cycle(u, 1'b1, 1'b0, c);
  endtask

  // Send one frame carrying value v; stops[0] is the first stop bit. Records the expected outcome.
  task automatic send_frame(input bit u, input int v, input bit pflip, input bit [1:0] stops);
    logic [2:0] c;
    int n  = u ? 5 : 8;
    int ns = u ? 2 : 1;
    bit msb = !u;
    en_cycle(u, 1'b0, 1'b0, c);
    for (int i = 0; i < n; i++) en_cycle(u, msb ? v[n-1-i] : v[i], 1'b0, c);
    if (PAR_EN) en_cycle(u, (^v) ^ PODD ^ pflip, 1'b0, c);
    for (int s = 0; s < ns; s++) begin
      en_cycle(u, stops[s], 1'b0, c);
      if (!stops[s]) begin
        if (u) exp_b.push_back('{ferr:1'b1, data:0, perr:1'b0});
        else   exp_a.push_back('{ferr:1'b1, data:0, perr:1'b0});
        merr_exp = 1'b1;
        return;
      end
    end
    if (u) exp_b.push_back('{ferr:1'b0, data:v, perr:PAR_EN & pflip});
    else   exp_a.push_back('{ferr:1'b0, data:v, perr:PAR_EN & pflip});
    if (PAR_EN & pflip) merr_exp = 1'b1;
  endtask

  task automatic compare_events(input string tag);
    check({tag, " a count"}, obs_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size(); i++)
      if (i < obs_a.size()) check($sformatf("%s a ev%0d", tag, i), pack_ev(obs_a[i]), pack_ev(exp_a[i]));
    check({tag, " b count"}, obs_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size(); i++)
      if (i < obs_b.size()) check($sformatf("%s b ev%0d", tag, i), pack_ev(obs_b[i]), pack_ev(exp_b[i]));
    exp_a.delete(); obs_a.delete(); exp_b.delete(); obs_b.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tv[$];
    logic [2:0] c;
    logic [7:0] a5;
    RST_N = 1'b0;
    en_a = 0; bit_a = 1; init_a = 0; en_b = 0; bit_b = 1; init_b = 0;
    idle(3);
    check("reset a", {a_busy, a_useful, a_last, a_valid, a_ferr, a_perr, a_merr, a_data}, '0);
    check("reset b", {b_busy, b_useful, b_last, b_valid, b_ferr, b_perr, b_merr, b_data}, '0);
    RST_N = 1'b1;
    idle(2);

    // Test 1: 0xA5 MSB first, comb outputs step by step.
    a5 = 8'hA5;
    tv.push_back('{init:1'b1, in_bit:1'b1, exp:3'b100 ^ 3'b100});
    tv.push_back('{init:1'b0, in_bit:1'b0, exp:3'b100});
    for (int i = 0; i < 8; i++)
      tv.push_back('{init:1'b0, in_bit:a5[7-i], exp:(i == 7) ? 3'b111 : 3'b110});
    if (PAR_EN) tv.push_back('{init:1'b0, in_bit:(^a5) ^ PODD, exp:3'b100});
    tv.push_back('{init:1'b0, in_bit:1'b1, exp:3'b100});
    tv.push_back('{init:1'b0, in_bit:1'b1, exp:3'b100});
    for (int i = 0; i < tv.size(); i++) begin
      en_cycle(1'b0, tv[i].in_bit, tv[i].init, c);
      check($sformatf("t1 comb step %0d", i), c, tv[i].exp);
    end
    exp_a.push_back('{ferr:1'b0, data:32'hA5, perr:1'b0});
    idle(3);
    check("t1 idle after msg", {a_busy, a_useful, a_last, a_merr}, 4'b0000);
    compare_events("t1");

    // Test 2: bad stop bit, then init_frame coinciding with the sticky-flag set.
    start_msg(1'b0);
    send_frame(1'b0, 32'h3C, 1'b0, 2'b00);
    init_a = 1'b1;
    @(posedge CLK); #1;
    init_a = 1'b0;
    check("t2 msg_err set wins", a_merr, 1'b1);
    check("t2 idle after frame_err", a_busy, 1'b0);
    idle(2);
    check("t2 msg_err sticky", a_merr, 1'b1);
    start_msg(1'b0);
    check("t2 msg_err cleared", a_merr, 1'b0);
    end_msg(1'b0);
    idle(3);
    compare_events("t2");

    // Test 3: back-to-back frames, busy drops after the idle start slot.
    start_msg(1'b0);
    send_frame(1'b0, 32'h01, 1'b0, 2'b11);
    send_frame(1'b0, 32'hFE, 1'b0, 2'b11);
    check("t3 busy before end", a_busy, 1'b1);
    end_msg(1'b0);
    check("t3 busy after end", a_busy, 1'b0);
    idle(3);
    compare_events("t3");

`ifdef UART_RX_PARITY_EN
    // Test 4: even parity on 0x07, wrong then right parity bit.
    start_msg(1'b0);
    send_frame(1'b0, 32'h07, 1'b1, 2'b11);
    end_msg(1'b0);
    idle(3);
    check("t4 msg_err on parity", a_merr, 1'b1);
    start_msg(1'b0);
    send_frame(1'b0, 32'h07, 1'b0, 2'b11);
    end_msg(1'b0);
    idle(3);
    check("t4 msg_err clean", a_merr, 1'b0);
    compare_events("t4");
`endif

    // Test 5: 5 bits LSB first, two stop bits; word appears only after the 2nd stop.
    start_msg(1'b1);
    en_cycle(1'b1, 1'b0, 1'b0, c);
    en_cycle(1'b1, 1'b1, 1'b0, c);
    en_cycle(1'b1, 1'b0, 1'b0, c);
    en_cycle(1'b1, 1'b1, 1'b0, c);
    en_cycle(1'b1, 1'b1, 1'b0, c);
    en_cycle(1'b1, 1'b0, 1'b0, c);
    if (PAR_EN) en_cycle(1'b1, 1'b1 ^ PODD, 1'b0, c);
    en_cycle(1'b1, 1'b1, 1'b0, c);
    idle(3);
    check("t5 no valid after 1st stop", obs_b.size(), 0);
    en_cycle(1'b1, 1'b1, 1'b0, c);
    exp_b.push_back('{ferr:1'b0, data:32'b01101, perr:1'b0});
    send_frame(1'b1, int'($urandom_range(31, 0)), 1'b0, 2'b01);
    end_msg(1'b1);
    idle(3);
    check("t5 msg_err after 2nd stop 0", b_merr, 1'b1);
    compare_events("t5");

    // Test 6: random messages with gapped strobes on both instances.
    gap_max = 15;
    for (int m = 0; m < 16; m++) begin
      bit u = m[0];
      int nf = int'($urandom_range(4, 1));
      start_msg(u);
      for (int f = 0; f < nf; f++) begin
        int v = int'($urandom_range(u ? 31 : 255, 0));
        bit pf = ($urandom_range(3, 0) == 0);
        bit [1:0] st = 2'b11;
        if ($urandom_range(7, 0) == 0) st = u ? 2'(1 << $urandom_range(1, 0)) ^ 2'b11 : 2'b00;
        send_frame(u, v, pf, st);
        if (st != 2'b11) break;
      end
      end_msg(u);
      idle(3);
      check($sformatf("t6 msg %0d msg_err", m), u ? b_merr : a_merr, merr_exp);
      compare_events($sformatf("t6 msg %0d", m));
    end

    // Reset asserted mid-DATA clears everything immediately.
    start_msg(1'b0);
    en_cycle(1'b0, 1'b0, 1'b0, c);
    for (int i = 0; i < 3; i++) en_cycle(1'b0, 1'b1, 1'b0, c);
    #2 RST_N = 1'b0;
    #1;
    check("t6 reset a", {a_busy, a_useful, a_last, a_valid, a_ferr, a_perr, a_merr, a_data}, '0);
    check("t6 reset b", {b_busy, b_useful, b_last, b_valid, b_ferr, b_perr, b_merr, b_data}, '0);
    idle(2);
    RST_N = 1'b1;
    gap_max = 0;
    idle(1);
    start_msg(1'b0);
    send_frame(1'b0, 32'h5A, 1'b0, 2'b11);
    end_msg(1'b0);
    idle(3);
    check("t6 clean after reset msg_err", a_merr, 1'b0);
    compare_events("t6 post reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
